// File: rtl/alu_cmd_issuer.sv
// Host-side command issuer for the FIFO/ALU pipeline: screens div-by-zero, throttles
// issue with an in-flight credit count, and tags returning results with their opcode.
module alu_cmd_issuer #(
  parameter int unsigned CREDITS   = 4,
  parameter int unsigned ISSUE_GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic       cmd_err,
  output logic [9:0] data,
  output logic       valid,
  input  logic       res_valid,
  input  logic [8:0] result,
  output logic       rsp_valid,
  output logic [1:0] rsp_op,
  output logic [8:0] rsp_data,
  output logic [2:0] in_flight,
  output logic       err_spurious
);

  localparam int unsigned OP_W   = 2;
  localparam int unsigned WORD_W = 10;
  localparam int unsigned RES_W  = 9;
  localparam int unsigned CNT_W  = 3;
  // Tag storage spans the full pointer range; only CREDITS slots are ever used.
  localparam int unsigned DEPTH  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OP_W-1:0]    tags_q [DEPTH];
  logic [OP_W-1:0]    tags_d [DEPTH];
  logic [WORD_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               cmd_err_q, cmd_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [OP_W-1:0]    rsp_op_q, rsp_op_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               err_spur_q, err_spur_d;
  logic               accept, div_zero, push, pop;

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(CREDITS - 1)) ? '0 : p + CNT_W'(1);
  endfunction

  // Next-state, handshake and tag FIFO control
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    in_flight_d = in_flight_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tags_d      = tags_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    cmd_err_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    err_spur_d  = err_spur_q;

    cmd_ready = (state_q == S_IDLE) && (in_flight_q < CNT_W'(CREDITS));
    accept    = cmd_valid && cmd_ready;
    div_zero  = accept && (cmd_op == 2'd3) && (cmd_b == 4'd0);
    push      = accept && !div_zero;
    pop       = res_valid && (in_flight_q != '0);

    case (state_q)
      S_IDLE: begin
        if (push) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (ISSUE_GAP != 0) begin
          state_d = S_GAP;
          gap_d   = CNT_W'(ISSUE_GAP);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        gap_d = gap_q - CNT_W'(1);
        if (gap_q <= CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_err_d = div_zero;
    if (push) begin
      data_d           = {cmd_op, cmd_b, cmd_a};
      valid_d          = 1'b1;
      tags_d[wr_ptr_q] = cmd_op;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    // Push can never target the slot being popped: push needs a free credit.
    if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = result;
      rsp_op_d    = tags_q[rd_ptr_q];
      rd_ptr_d    = ptr_inc(rd_ptr_q);
    end

    if (res_valid && (in_flight_q == '0)) err_spur_d = 1'b1;

    case ({push, pop})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      in_flight_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tags_q[i] <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      err_spur_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      in_flight_q <= in_flight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tags_q      <= tags_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      cmd_err_q   <= cmd_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      err_spur_q  <= err_spur_d;
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign cmd_err      = cmd_err_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_op       = rsp_op_q;
  assign rsp_data     = rsp_data_q;
  assign in_flight    = in_flight_q;
  assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: per-cycle reference model plus a response scoreboard.
module tb_alu_cmd_issuer;

  localparam int unsigned CREDITS   = 4;
  localparam int unsigned ISSUE_GAP = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       cmd_err;
  logic [9:0] data;
  logic       valid;
  logic       res_valid;
  logic [8:0] result;
  logic       rsp_valid;
  logic [1:0] rsp_op;
  logic [8:0] rsp_data;
  logic [2:0] in_flight;
  logic       err_spurious;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.CREDITS(CREDITS), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_err(cmd_err),
    .data(data), .valid(valid),
    .res_valid(res_valid), .result(result),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .in_flight(in_flight), .err_spurious(err_spurious)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [8:0] d;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [1:0] tag_q[$];
  int         checks = 0;
  int         failures = 0;
  int         m_state, m_gap, m_if, n_iss;
  logic       e_valid, e_err, e_rsp_valid, e_spur;
  logic [9:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    rsp_t r;
    chk("valid", 32'(valid), 32'(e_valid));
    chk("data", 32'(data), 32'(e_data));
    chk("cmd_err", 32'(cmd_err), 32'(e_err));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    chk("in_flight", 32'(in_flight), 32'(m_if));
    chk("err_spurious", 32'(err_spurious), 32'(e_spur));
    if (e_rsp_valid && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("rsp_op", 32'(rsp_op), 32'(r.op));
      chk("rsp_data", 32'(rsp_data), 32'(r.d));
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_gap = 0; m_if = 0;
    tag_q.delete(); exp_q.delete();
    e_valid = 1'b0; e_err = 1'b0; e_rsp_valid = 1'b0; e_spur = 1'b0; e_data = '0;
  endtask

  // One clock: drive inputs now, predict the next cycle, then check after the edge.
  task automatic step(input logic rst, input logic cv, input logic [1:0] op,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic rv, input logic [8:0] res);
    logic exp_ready, acc, d0, iss, pop;
    rsp_t r;
    reset = rst; cmd_valid = cv; cmd_op = op; cmd_a = a; cmd_b = b;
    res_valid = rv; result = res;
    exp_ready = (m_state == 0) && (m_if < int'(CREDITS));
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    if (rst) begin
      model_reset();
    end else begin
      acc = cv && exp_ready;
      d0  = acc && (op == 2'd3) && (b == 4'd0);
      iss = acc && !d0;
      pop = rv && (m_if > 0);
      e_valid = iss; e_err = d0; e_rsp_valid = pop;
      if (iss) begin
        e_data = {op, b, a};
        tag_q.push_back(op);
        n_iss++;
      end
      if (pop) begin
        r.op = tag_q.pop_front();
        r.d  = res;
        exp_q.push_back(r);
      end
      if (rv && m_if == 0) e_spur = 1'b1;
      m_if = m_if + (iss ? 1 : 0) - (pop ? 1 : 0);
      case (m_state)
        0: if (iss) m_state = 1;
        1: begin
          if (ISSUE_GAP > 0) begin m_state = 2; m_gap = int'(ISSUE_GAP); end
          else m_state = 0;
        end
        default: begin
          if (m_gap <= 1) m_state = 0;
          m_gap--;
        end
      endcase
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 9'd0);
  endtask

  task automatic result_in(input logic [8:0] res);
    step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, res);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    res_valid = 1'b0; result = '0; n_iss = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_outs();

    // Single add: issue pulse, gap, then tagged response
    step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 9'd0);
    step(1'b0, 1'b1, 2'd0, 4'd3, 4'd5, 1'b0, 9'd0);
    chk("t1_data", 32'(data), 32'h053);
    chk("t1_valid", 32'(valid), 32'd1);
    idle(3);
    chk("t1_in_flight", 32'(in_flight), 32'd1);
    result_in(9'd8);
    chk("t1_rsp_op", 32'(rsp_op), 32'd0);
    chk("t1_rsp_data", 32'(rsp_data), 32'd8);
    idle(1);

    // Credit stall with cmd_valid held; opcode changes only after each accept
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 2'(n_iss % 3), 4'd1, 4'd2, 1'b0, 9'd0);
    chk("t2_full", 32'(in_flight), 32'd4);
    chk("t2_stall_ready", 32'(cmd_ready), 32'd0);
    step(1'b0, 1'b1, 2'(n_iss % 3), 4'd1, 4'd2, 1'b1, 9'd3);
    chk("t2_ready_after_result", 32'(cmd_ready), 32'd1);
    // Accept and result on the same edge
    step(1'b0, 1'b1, 2'(n_iss % 3), 4'd1, 4'd2, 1'b1, 9'd4);
    chk("t2_same_edge", 32'(in_flight), 32'd3);
    result_in(9'd5);
    result_in(9'd6);
    result_in(9'd7);
    chk("t2_drained", 32'(in_flight), 32'd0);
    idle(2);

    // Mixed opcodes come back in issue order
    step(1'b0, 1'b1, 2'd2, 4'd2, 4'd6, 1'b0, 9'd0);
    idle(2);
    step(1'b0, 1'b1, 2'd1, 4'd5, 4'd3, 1'b0, 9'd0);
    idle(2);
    step(1'b0, 1'b1, 2'd3, 4'd9, 4'd3, 1'b0, 9'd0);
    idle(2);
    result_in(9'd12);
    chk("t3_op0", 32'(rsp_op), 32'd2);
    chk("t3_d0", 32'(rsp_data), 32'd12);
    result_in(9'd2);
    chk("t3_op1", 32'(rsp_op), 32'd1);
    chk("t3_d1", 32'(rsp_data), 32'd2);
    result_in(9'd3);
    chk("t3_op2", 32'(rsp_op), 32'd3);
    chk("t3_d2", 32'(rsp_data), 32'd3);
    idle(1);

    // Divide by zero is rejected without issue
    step(1'b0, 1'b1, 2'd3, 4'd7, 4'd0, 1'b0, 9'd0);
    chk("t4_err", 32'(cmd_err), 32'd1);
    chk("t4_no_valid", 32'(valid), 32'd0);
    chk("t4_in_flight", 32'(in_flight), 32'd0);
    idle(2);

    // Spurious result is sticky until reset
    result_in(9'h1AA);
    chk("t5_spurious", 32'(err_spurious), 32'd1);
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    idle(3);
    step(1'b0, 1'b1, 2'd0, 4'd4, 4'd4, 1'b0, 9'd0);
    idle(2);
    step(1'b0, 1'b1, 2'd2, 4'd3, 4'd3, 1'b0, 9'd0);
    idle(1);
    chk("t5_two_in_flight", 32'(in_flight), 32'd2);
    chk("t5_still_sticky", 32'(err_spurious), 32'd1);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 9'd0);
    chk("t5_rst_in_flight", 32'(in_flight), 32'd0);
    chk("t5_rst_spurious", 32'(err_spurious), 32'd0);
    chk("t5_rst_ready", 32'(cmd_ready), 32'd1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
